// File: rtl/sd_sim_loader_pkg.sv
// Shared constants, state type and byte-placement helper for the SD_SIM write-side loader.
// Used by sd_sim_loader and sd_sim_loader_word_packer.
package sd_sim_loader_pkg;

   localparam int BLOCK_W        = 128;
   localparam int BYTES_PER_WORD = 16;
   localparam int IDX_W          = 5;

   // Record addresses the cracker's read path expects.
   localparam int HASH_ADDR  = 0;
   localparam int KEY_ADDR   = 1;
   localparam int DICT_START = 2;

   localparam logic [IDX_W-1:0] FULL_COUNT = 5'd16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_WRITE   = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Big-endian placement: byte 0 lands in [127:120], byte 15 in [7:0].
   function automatic logic [BLOCK_W-1:0] place_byte(input logic [BLOCK_W-1:0] w,
                                                     input logic [3:0]         idx,
                                                     input logic [7:0]         b);
      return w | ({b, 120'd0} >> {idx, 3'b000});
   endfunction

endpackage

// File: rtl/sd_sim_loader_word_packer.sv
// Collects stream bytes into a 128-bit word. Slots are cleared to zero on every clear, so a
// partially filled word is already zero-padded when it is flushed.
module sd_sim_loader_word_packer
   import sd_sim_loader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               push,
   input  logic [7:0]         data,
   output logic [BLOCK_W-1:0] word,
   output logic [IDX_W-1:0]   count
);

   logic [BLOCK_W-1:0] word_q;
   logic [IDX_W-1:0]   count_q;

   // Next word/count, including any byte pushed this cycle; the top registers these into dina.
   always_comb begin
      word  = word_q;
      count = count_q;
      if (clear) begin
         word  = {BLOCK_W{1'b0}};
         count = {IDX_W{1'b0}};
      end else if (push && (count_q < FULL_COUNT)) begin
         word  = place_byte(word_q, count_q[3:0], data);
         count = count_q + 5'd1;
      end else begin
         word  = word_q;
         count = count_q;
      end
   end

   // Packing state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         word_q  <= {BLOCK_W{1'b0}};
         count_q <= {IDX_W{1'b0}};
      end else begin
         word_q  <= word;
         count_q <= count;
      end
   end

endmodule

// File: rtl/sd_sim_loader.sv
// Byte-stream to SD_SIM BRAM loader: packs 16 bytes per word and writes sequential addresses.
// Optional macro LOADER_CHECKSUM_EN adds an XOR checksum output of all accepted bytes.
module sd_sim_loader
   import sd_sim_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 256
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               load_start,
   input  logic               load_end,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               byte_ready,
   output logic               wea,
   output logic [ADDR_W-1:0]  addra,
   output logic [BLOCK_W-1:0] dina,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   output logic [ADDR_W:0]    words_written
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0]         checksum
`endif
);

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_t             state;
   logic [ADDR_W-1:0]  ptr;
   logic               end_pending;
   logic               xfer;
   logic               is_full;
   logic               restart;
   logic               pk_clear;
   logic               pk_push;
   logic [BLOCK_W-1:0] pk_word;
   logic [IDX_W-1:0]   pk_count;

   sd_sim_loader_word_packer u_packer (
      .clk   (clk),
      .reset (reset),
      .clear (pk_clear),
      .push  (pk_push),
      .data  (byte_data),
      .word  (pk_word),
      .count (pk_count)
   );

   // Handshake decode and packer control; bytes arriving once full are consumed but not packed.
   always_comb begin
      xfer     = byte_valid & byte_ready;
      is_full  = (words_written == DEPTH_W);
      restart  = load_start && (state != ST_FLUSH);
      pk_clear = 1'b0;
      pk_push  = 1'b0;
      case (state)
         ST_COLLECT: begin
            if (load_start) begin
               pk_clear = 1'b1;
            end else begin
               pk_push = xfer & ~is_full;
            end
         end
         ST_WRITE, ST_FLUSH: pk_clear = 1'b1;
         ST_IDLE, ST_DONE:   pk_clear = load_start;
         default:            pk_clear = 1'b1;
      endcase
   end

   // Loader FSM with registered BRAM port and status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_IDLE;
         ptr           <= BASE;
         end_pending   <= 1'b0;
         byte_ready    <= 1'b0;
         wea           <= 1'b0;
         addra         <= {ADDR_W{1'b0}};
         dina          <= {BLOCK_W{1'b0}};
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         words_written <= {(ADDR_W+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
         checksum      <= 8'h00;
`endif
      end else if (restart) begin
         // A restart during WRITE lets that write finish; partial bytes are simply discarded.
         state         <= ST_COLLECT;
         ptr           <= BASE;
         end_pending   <= 1'b0;
         byte_ready    <= 1'b1;
         wea           <= 1'b0;
         busy          <= 1'b1;
         done          <= 1'b0;
         overflow      <= 1'b0;
         words_written <= {(ADDR_W+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
         checksum      <= 8'h00;
`endif
      end else begin
         wea <= 1'b0;
         case (state)
            ST_COLLECT: begin
`ifdef LOADER_CHECKSUM_EN
               if (xfer) checksum <= checksum ^ byte_data;
`endif
               if (xfer && is_full) overflow <= 1'b1;
               if (pk_count == FULL_COUNT) begin
                  state       <= ST_WRITE;
                  wea         <= 1'b1;
                  addra       <= ptr;
                  dina        <= pk_word;
                  byte_ready  <= 1'b0;
                  end_pending <= load_end;
               end else if (load_end && (pk_count != {IDX_W{1'b0}})) begin
                  state      <= ST_FLUSH;
                  wea        <= 1'b1;
                  addra      <= ptr;
                  dina       <= pk_word;
                  byte_ready <= 1'b0;
               end else if (load_end) begin
                  state      <= ST_DONE;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  byte_ready <= 1'b0;
               end
            end
            ST_WRITE: begin
               ptr           <= ptr + 1'b1;
               words_written <= words_written + 1'b1;
               end_pending   <= 1'b0;
               if (end_pending) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state      <= ST_COLLECT;
                  byte_ready <= 1'b1;
               end
            end
            ST_FLUSH: begin
               ptr           <= ptr + 1'b1;
               words_written <= words_written + 1'b1;
               state         <= ST_DONE;
               done          <= 1'b1;
               busy          <= 1'b0;
            end
            ST_IDLE, ST_DONE: begin
               byte_ready <= 1'b0;
            end
            default: begin
               state      <= ST_IDLE;
               byte_ready <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
